// File: rtl/mem_stage_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the memory-stage sequencer.
// The sequencer takes the slave modport; the EX/MEM register and memory port side take the master modport.
interface mem_stage_ctrl_if;
    logic        valid_in;
    logic [3:0]  opcode;
    logic [15:0] addr_in;
    logic [15:0] store_data;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] load_data;
    logic        valid_out;
    logic        stall;
    logic        mem_error;

    modport slave (
        input  valid_in, opcode, addr_in, store_data, mem_rdata, mem_resp,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output load_data, valid_out, stall, mem_error
    );

    modport master (
        output valid_in, opcode, addr_in, store_data, mem_rdata, mem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  load_data, valid_out, stall, mem_error
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: turns latched LC-3b loads/stores (incl. LDI/STI and byte ops) into 16-bit memory requests.
// Latency 3 cycles accept-to-DONE (4 for LDI/STI) with 1-cycle memory; stall freezes the pipeline until DONE.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    mem_stage_ctrl_if.slave bus
);
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS1, ACCESS2, DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [15:0] r_addr;
    logic [15:0] r_sdata;
    logic [15:0] r_ptr;
    logic [CW-1:0] r_wait_cnt;
    logic [15:0] r_load_data;
    logic        r_valid_out;
    logic        r_mem_error;

    logic        w_mem_op;
    logic        w_is_ind;
    logic        w_is_byte;
    logic        w_is_store;
    logic        w_expire;
    logic [15:0] w_target;
    logic [7:0]  w_lbyte;
    logic [15:0] w_load_val;

    assign w_mem_op   = (bus.opcode == OP_LDR) || (bus.opcode == OP_LDB) || (bus.opcode == OP_LDI) ||
                        (bus.opcode == OP_STR) || (bus.opcode == OP_STB) || (bus.opcode == OP_STI);
    assign w_is_ind   = (r_op == OP_LDI) || (r_op == OP_STI);
    assign w_is_byte  = (r_op == OP_LDB) || (r_op == OP_STB);
    assign w_is_store = (r_op == OP_STR) || (r_op == OP_STB) || (r_op == OP_STI);
    assign w_target   = w_is_ind ? r_ptr : r_addr;
    assign w_lbyte    = w_target[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
    assign w_load_val = w_is_byte ? {{8{w_lbyte[7]}}, w_lbyte} : bus.mem_rdata;
    // Expiry fires on the last allowed wait cycle; a mem_resp in that same cycle takes priority.
    assign w_expire   = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    assign bus.load_data = r_load_data;
    assign bus.valid_out = r_valid_out;
    assign bus.mem_error = r_mem_error;

    // Request fields derive only from latched operands, so they stay stable for the whole access.
    always_comb begin
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 16'h0000;
        bus.mem_wdata       = 16'h0000;
        bus.mem_byte_enable = 2'b00;
        bus.stall           = 1'b0;
        case (r_state)
            IDLE: bus.stall = bus.valid_in & w_mem_op;
            ACCESS1: begin
                bus.mem_read        = 1'b1;
                bus.mem_address     = {r_addr[15:1], 1'b0};
                bus.mem_byte_enable = 2'b11;
                bus.stall           = 1'b1;
            end
            ACCESS2: begin
                bus.mem_read  = ~w_is_store;
                bus.mem_write = w_is_store;
                bus.stall     = 1'b1;
                if (w_is_byte) begin
                    bus.mem_address     = w_target;
                    bus.mem_byte_enable = w_target[0] ? 2'b10 : 2'b01;
                    bus.mem_wdata       = {r_sdata[7:0], r_sdata[7:0]};
                end else begin
                    bus.mem_address     = {w_target[15:1], 1'b0};
                    bus.mem_byte_enable = 2'b11;
                    bus.mem_wdata       = r_sdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= 4'h0;
            r_addr      <= 16'h0000;
            r_sdata     <= 16'h0000;
            r_ptr       <= 16'h0000;
            r_wait_cnt  <= '0;
            r_load_data <= 16'h0000;
            r_valid_out <= 1'b0;
            r_mem_error <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.valid_in && w_mem_op) begin
                        r_op       <= bus.opcode;
                        r_addr     <= bus.addr_in;
                        r_sdata    <= bus.store_data;
                        r_wait_cnt <= '0;
                        r_state    <= ((bus.opcode == OP_LDI) || (bus.opcode == OP_STI)) ? ACCESS1 : ACCESS2;
                    end
                end
                ACCESS1: begin
                    if (bus.mem_resp) begin
                        r_ptr      <= bus.mem_rdata;
                        r_wait_cnt <= '0;
                        r_state    <= ACCESS2;
                    end else if (w_expire) begin
                        r_mem_error <= 1'b1;
                        r_load_data <= 16'h0000;
                        r_valid_out <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ACCESS2: begin
                    if (bus.mem_resp) begin
                        if (!w_is_store) r_load_data <= w_load_val;
                        r_valid_out <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_expire) begin
                        r_mem_error <= 1'b1;
                        r_load_data <= 16'h0000;
                        r_valid_out <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized scoreboard bench: a reference model predicts requests and results; a memory responder and
// an output monitor pop and compare as the DUT presents them.
module tb_mem_stage_ctrl;
    localparam int TO = 6;
    localparam int NEVER = 1000;
    localparam logic [3:0] OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3, OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7, OP_LDI = 4'hA, OP_STI = 4'hB;

    typedef struct packed { logic rd; logic wr; logic [15:0] addr; logic [1:0] be; logic [15:0] wdata; } req_t;
    typedef struct packed { logic [15:0] data; logic err; } res_t;

    logic clk = 1'b0;
    logic reset;
    mem_stage_ctrl_if bus();
    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    req_t        req_q[$];
    res_t        res_q[$];
    int          dly_q[$];
    logic [15:0] phys[int];
    logic [15:0] refm[int];
    logic [15:0] m_load = 16'h0000;
    logic        m_err = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          late_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input int w);
        logic [31:0] h;
        h = w * 40503;
        return h[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] phys_rd(input int w);
        return phys.exists(w) ? phys[w] : init_word(w);
    endfunction

    function automatic logic [15:0] ref_rd(input int w);
        return refm.exists(w) ? refm[w] : init_word(w);
    endfunction

    // Memory responder: checks each request against the model, its stability, then answers after its delay.
    initial begin
        bit   active;
        req_t cur, cap, cmp, exp_r;
        int   cnt, dly, late_done, idx;
        logic [15:0] w;
        active = 0; cnt = 0; dly = 0; late_done = 0;
        bus.mem_resp = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            if (late_done != late_req) begin
                late_done = late_req;
                bus.mem_resp = 1'b1;
                bus.mem_rdata = 16'hDEAD;
            end
            if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
                cur = {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byte_enable, bus.mem_wdata};
                if (!active) begin
                    active = 1; cnt = 0; cap = cur;
                    if (req_q.size() == 0 || dly_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_request: got %h expected none", cur);
                        dly = NEVER;
                    end else begin
                        exp_r = req_q.pop_front();
                        dly = dly_q.pop_front();
                        cmp = cur;
                        if (!exp_r.wr) begin
                            cmp.wdata = 16'h0000;
                            exp_r.wdata = 16'h0000;
                        end
                        chk("request", cmp, exp_r);
                    end
                end else begin
                    chk("req_stable", cur, cap);
                end
                if (cnt == dly) begin
                    idx = int'(cur.addr[15:1]);
                    bus.mem_resp = 1'b1;
                    bus.mem_rdata = phys_rd(idx);
                    if (cur.wr) begin
                        w = phys_rd(idx);
                        if (cur.be[1]) w[15:8] = cur.wdata[15:8];
                        if (cur.be[0]) w[7:0] = cur.wdata[7:0];
                        phys[idx] = w;
                    end
                    active = 0;
                end
                cnt++;
            end else begin
                active = 0;
            end
        end
    end

    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid_out: got 1 expected 0");
                end else begin
                    e = res_q.pop_front();
                    chk("load_data", bus.load_data, e.data);
                    chk("mem_error", bus.mem_error, e.err);
                end
            end
        end
    end

    // Predicts the whole op from the architectural rules, then drives it and garbles inputs while busy.
    task automatic run_op(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] sd,
                          input int d1, input int d2);
        bit ind, byt, st, to, stall_ok;
        logic [15:0] tgt, w;
        logic [7:0]  b;
        int exp_cyc, n;
        ind = (op == OP_LDI) || (op == OP_STI);
        byt = (op == OP_LDB) || (op == OP_STB);
        st  = (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
        to = 0; stall_ok = 1; tgt = addr; exp_cyc = 1;
        if (ind) begin
            req_q.push_back({1'b1, 1'b0, addr & 16'hFFFE, 2'b11, 16'h0000});
            dly_q.push_back(d1);
            if (d1 >= TO) begin
                to = 1; exp_cyc += TO;
            end else begin
                exp_cyc += d1 + 1;
                tgt = ref_rd(int'(addr[15:1]));
            end
        end
        if (!to) begin
            req_q.push_back({~st, st, byt ? tgt : (tgt & 16'hFFFE),
                             byt ? (tgt[0] ? 2'b10 : 2'b01) : 2'b11,
                             byt ? {sd[7:0], sd[7:0]} : sd});
            dly_q.push_back(d2);
            if (d2 >= TO) begin
                to = 1; exp_cyc += TO;
            end else begin
                exp_cyc += d2 + 1;
                w = ref_rd(int'(tgt[15:1]));
                if (!st) begin
                    b = tgt[0] ? w[15:8] : w[7:0];
                    m_load = byt ? {{8{b[7]}}, b} : w;
                end else begin
                    if (!byt) w = sd;
                    else if (tgt[0]) w[15:8] = sd[7:0];
                    else w[7:0] = sd[7:0];
                    refm[int'(tgt[15:1])] = w;
                end
            end
        end
        if (to) begin
            m_load = 16'h0000;
            m_err = 1'b1;
        end
        res_q.push_back({m_load, m_err});

        @(negedge clk);
        bus.valid_in = 1'b1; bus.opcode = op; bus.addr_in = addr; bus.store_data = sd;
        #1 chk("stall_accept", bus.stall, 1);
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.valid_out === 1'b1 || n > 200) break;
            if (bus.stall !== 1'b1) stall_ok = 0;
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.opcode = 4'($urandom);
            bus.addr_in = 16'($urandom);
            bus.store_data = 16'($urandom);
        end
        chk("latency", n, exp_cyc);
        chk("stall_busy", stall_ok, 1);
        chk("stall_done", bus.stall, 0);
        bus.valid_in = 1'b0;
    endtask

    logic [3:0] ops[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d1, d2;
        ops = '{OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI};
        bus.valid_in = 1'b0; bus.opcode = 4'h0; bus.addr_in = 16'h0000; bus.store_data = 16'h0000;
        reset = 1'b1;
        phys[int'(16'h3000 >> 1)] = 16'hBEEF; refm[int'(16'h3000 >> 1)] = 16'hBEEF;
        phys[int'(16'h4002 >> 1)] = 16'h80FF; refm[int'(16'h4002 >> 1)] = 16'h80FF;
        phys[int'(16'h6000 >> 1)] = 16'h7005; refm[int'(16'h6000 >> 1)] = 16'h7005;
        phys[int'(16'h7004 >> 1)] = 16'h0042; refm[int'(16'h7004 >> 1)] = 16'h0042;
        repeat (2) @(negedge clk);
        chk("rst_load_data", bus.load_data, 0);
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_mem_error", bus.mem_error, 0);
        chk("rst_read_write", {bus.mem_read, bus.mem_write}, 0);
        chk("rst_byte_en", bus.mem_byte_enable, 0);
        chk("rst_stall", bus.stall, 0);
        reset = 1'b0;

        run_op(OP_LDR, 16'h3001, 16'h0000, 0, 0);
        run_op(OP_LDB, 16'h4003, 16'h0000, 0, 0);
        run_op(OP_LDB, 16'h4002, 16'h0000, 0, 1);
        run_op(OP_STB, 16'h5001, 16'h1234, 0, 0);
        run_op(OP_STR, 16'h5000, 16'h1234, 0, 2);
        run_op(OP_LDI, 16'h6000, 16'h0000, 5, 5);
        run_op(OP_STI, 16'h6000, 16'h9999, 5, 5);
        run_op(OP_LDR, 16'h7004, 16'h0000, 0, 0);
        run_op(OP_LDR, 16'h3000, 16'h0000, 0, TO - 1);
        run_op(OP_LDR, 16'h3000, 16'h0000, 0, NEVER);
        run_op(OP_LDR, 16'h4002, 16'h0000, 0, 0);
        run_op(OP_LDI, 16'h6000, 16'h0000, NEVER, 0);

        @(negedge clk);
        bus.valid_in = 1'b1; bus.opcode = OP_ADD; bus.addr_in = 16'h3000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("add_no_stall", bus.stall, 0);
            @(negedge clk);
        end
        bus.valid_in = 1'b0;

        req_q.push_back({1'b1, 1'b0, 16'h6000, 2'b11, 16'h0000});
        dly_q.push_back(NEVER);
        bus.valid_in = 1'b1; bus.opcode = OP_STI; bus.addr_in = 16'h6000; bus.store_data = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("abort_in_access1", bus.mem_read, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_load = 16'h0000; m_err = 1'b0;
        chk("abort_read_write", {bus.mem_read, bus.mem_write}, 0);
        chk("abort_stall", bus.stall, 0);
        chk("abort_valid_out", bus.valid_out, 0);
        late_req++;
        repeat (3) @(negedge clk);
        chk("late_resp_load", bus.load_data, 0);
        chk("late_resp_error", bus.mem_error, 0);

        for (int i = 0; i < 40; i++) begin
            d1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
            d2 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
            run_op(ops[$urandom_range(0, 5)], 16'h8000 | 16'($urandom_range(0, 31)), 16'($urandom), d1, d2);
        end

        repeat (4) @(negedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage access sequencer for the pipelined LC-3b core. It sits between the EX/MEM pipeline register and the data-memory port, which is backed by the 128-bit-line data cache.
It consumes the latched opcode, effective address and store data, and issues 16-bit data-memory requests. It sequences the two-access indirect ops (LDI/STI), applies byte lanes for LDB/STB, and stalls the pipeline until the final access completes.
Its load result feeds the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles one access may wait for mem_resp before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  EX/MEM holds a valid instruction
opcode  in  4  lc3b_opcode from the EX/MEM control word
addr_in  in  16  effective address computed in EX
store_data  in  16  SR value for STR/STB/STI
mem_rdata  in  16  data-memory read data
mem_resp  in  1  data-memory access complete (single-cycle pulse)
mem_read  out  1  read request
mem_write  out  1  write request
mem_address  out  16  request address
mem_wdata  out  16  write data
mem_byte_enable  out  2  byte lanes ([1]=high byte)
load_data  out  16  load result to MEM/WB
valid_out  out  1  memory op finished this cycle; load_data valid
stall  out  1  freeze IF..EX/MEM registers
mem_error  out  1  sticky timeout flag

Behaviour:
- Memory ops: op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti. All other opcodes pass through: no request, stall=0, valid_out=0.
- States: IDLE, ACCESS1, ACCESS2, DONE.
- Reset (synchronous): state=IDLE. Registered outputs clear: load_data=0, valid_out=0, mem_error=0. Combinational outputs in IDLE with no memory op: mem_read=0, mem_write=0, mem_byte_enable=00, stall=0.
- IDLE:
  - stall = valid_in & mem_op (combinational).
  - On valid_in & mem_op, latch opcode, addr_in and store_data. Next state is ACCESS1 for LDI/STI, otherwise ACCESS2.
  - mem_resp in IDLE or DONE is ignored.
- ACCESS1 (indirect pointer fetch):
  - mem_read=1; mem_address={addr[15:1],0}; byte_enable=11; stall=1.
  - On mem_resp: latch pointer=mem_rdata, then go to ACCESS2.
- ACCESS2 (final access, stall=1):
  - Target address is the latched addr for LDR/LDB/STR/STB, and the pointer for LDI/STI.
  - Loads assert mem_read; stores assert mem_write.
  - Word ops (LDR/LDI/STR/STI): mem_address={target[15:1],0}; byte_enable=11; mem_wdata=store_data.
  - Byte ops (LDB/STB): mem_address=target; byte_enable = target[0] ? 10 : 01; mem_wdata={store_data[7:0],store_data[7:0]}.
  - On mem_resp, load_data is registered as:
    - word load: mem_rdata;
    - LDB: sign-extend of mem_rdata[15:8] if target[0]=1, else of mem_rdata[7:0];
    - store: unchanged.
  - Then go to DONE.
- DONE (one cycle): valid_out=1, stall=0, no request. The pipeline advances at the end of this cycle; next state is IDLE.
- Request stability: mem_read, mem_write, mem_address, mem_wdata and mem_byte_enable are held constant from first assertion until the mem_resp cycle inclusive. They deassert the cycle after.
- Latched operands are immune to changes on addr_in, store_data or opcode while not in IDLE.
- Timeout (TIMEOUT_CYCLES>0):
  - A wait counter clears on entry to ACCESS1/ACCESS2 and increments each cycle without mem_resp.
  - When it reaches TIMEOUT_CYCLES: set mem_error (sticky until reset), force load_data=0, go to DONE.
  - mem_resp arriving in the same cycle as expiry wins; no error is raised.
- Reset mid-access: requests drop the cycle after the reset edge and no valid_out is generated. A pending mem_resp arriving afterwards is ignored.
- Back-to-back memory ops cost one IDLE cycle between them: DONE→IDLE, then accept.
- Latency with 1-cycle memory: LDR/STR/LDB/STB take 3 cycles from acceptance to the end of DONE; LDI/STI take 4.

Test Plan:
- LDR, addr_in=x3001, memory returns mem_rdata=xBEEF after 1 cycle → mem_address=x3000, be=11, stall=1 for 2 cycles, then valid_out=1 with load_data=xBEEF.
- LDB, addr_in=x4003, mem_rdata=x80FF → be=10, load_data=xFF80. Repeat with addr_in=x4002 → be=01, load_data=xFFFF.
- STB, addr_in=x5001, store_data=x1234 → mem_write=1, mem_wdata=x3434, be=10, no load_data change. Then STR at x5000 → be=11, mem_wdata=x1234.
- LDI, addr_in=x6000 returns pointer x7005, then x7004 returns x0042 → first read at x6000, second at x7004, load_data=x0042. STI with the same pointer writes store_data to x7004, be=11. Requests stay stable across 5-cycle resp delays.
- TIMEOUT_CYCLES=4, LDR with no mem_resp → after 4 wait cycles mem_error=1, load_data=0, valid_out pulse, return to IDLE. A next LDR with prompt resp completes normally with mem_error still 1.
- Reset asserted during ACCESS1 of an STI → next cycle mem_read=mem_write=0, stall=0, state IDLE. A late mem_resp has no effect. An ADD opcode with valid_in=1 never asserts stall.
